// File: rtl/oled_cmd_seq.sv
// oled_cmd_seq: power-up and command sequencer in front of the OLED SPI byte
// transmitter. Pulses RES_N, waits for panel power-up, streams the init list,
// optionally clears display RAM, then forwards user bytes one transfer at a time.
// Build option: define OLED_CLEAR_EN to include the display RAM clear phase.
module oled_cmd_seq #(
   parameter int RST_LOW_CYC = 250,
   parameter int PWR_DELAY   = 2500000
) (
   input  logic       CLK,
   input  logic       RST,
   output logic       RES_N,
   output logic [9:0] SPI_DATA,
   output logic       SPI_START,
   input  logic       SPI_DONE,
   output logic       READY,
   input  logic       WR_VALID,
   input  logic       WR_DC,
   input  logic [7:0] WR_BYTE,
   output logic       WR_ACCEPT,
   output logic       BUSY
);

   // One shared delay counter serves both the reset pulse and the power-up wait.
   localparam int MAX_DLY = (PWR_DELAY > RST_LOW_CYC) ? PWR_DELAY : RST_LOW_CYC;
   localparam int CW      = ($clog2(MAX_DLY + 1) > 22) ? $clog2(MAX_DLY + 1) : 22;
   localparam logic [CW-1:0] RST_LAST  = CW'(RST_LOW_CYC - 1);
   localparam logic [CW-1:0] PWR_LAST  = CW'(PWR_DELAY - 1);
   localparam logic [4:0]    INIT_LAST = 5'd24;

`ifdef OLED_CLEAR_EN
   typedef enum logic [2:0] {
      S_RST_LO, S_PWR_WAIT, S_INIT_ISSUE, S_INIT_WAIT,
      S_CLR_ISSUE, S_CLR_WAIT, S_IDLE, S_USER_WAIT
   } state_t;
   localparam logic [7:0] COL_LAST  = 8'd130;
   localparam logic [2:0] PAGE_LAST = 3'd7;
`else
   typedef enum logic [2:0] {
      S_RST_LO, S_PWR_WAIT, S_INIT_ISSUE, S_INIT_WAIT,
      S_IDLE, S_USER_WAIT
   } state_t;
`endif

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [4:0]    idx, idx_n;
   logic          res_n_n, start_n, ready_n, accept_n, busy_n;
   logic [9:0]    data_n;
`ifdef OLED_CLEAR_EN
   logic [2:0]    page, page_n;
   logic [7:0]    col, col_n;
`endif

   // SSD1306 init command list, all sent with DC=0.
   function automatic logic [7:0] init_byte(input logic [4:0] i);
      logic [7:0] b;
      case (i)
         5'd0:  b = 8'hAE;  5'd1:  b = 8'hD5;  5'd2:  b = 8'h80;  5'd3:  b = 8'hA8;
         5'd4:  b = 8'h3F;  5'd5:  b = 8'hD3;  5'd6:  b = 8'h00;  5'd7:  b = 8'h40;
         5'd8:  b = 8'h8D;  5'd9:  b = 8'h14;  5'd10: b = 8'h20;  5'd11: b = 8'h02;
         5'd12: b = 8'hA1;  5'd13: b = 8'hC8;  5'd14: b = 8'hDA;  5'd15: b = 8'h12;
         5'd16: b = 8'h81;  5'd17: b = 8'hCF;  5'd18: b = 8'hD9;  5'd19: b = 8'hF1;
         5'd20: b = 8'hDB;  5'd21: b = 8'h40;  5'd22: b = 8'hA4;  5'd23: b = 8'hA6;
         default: b = 8'hAF;
      endcase
      return b;
   endfunction

`ifdef OLED_CLEAR_EN
   // Per page: set page address, column low/high = 0, then 128 zero data bytes.
   function automatic logic [9:0] clr_word(input logic [2:0] p, input logic [7:0] c);
      logic [9:0] w;
      case (c)
         8'd0:    w = {2'b00, 4'hB, 1'b0, p};
         8'd1:    w = 10'h000;
         8'd2:    w = 10'h010;
         default: w = 10'h100;
      endcase
      return w;
   endfunction
`endif

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      res_n_n  = RES_N;
      data_n   = SPI_DATA;
      start_n  = 1'b0;
      ready_n  = READY;
      accept_n = 1'b0;
      busy_n   = BUSY;
`ifdef OLED_CLEAR_EN
      page_n   = page;
      col_n    = col;
`endif
      case (state)
         S_RST_LO: begin
            if (cnt == RST_LAST) begin
               cnt_n   = '0;
               res_n_n = 1'b1;
               state_n = S_PWR_WAIT;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_PWR_WAIT: begin
            if (cnt == PWR_LAST) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = S_INIT_ISSUE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_INIT_ISSUE: begin
            data_n  = {2'b00, init_byte(idx)};
            start_n = 1'b1;
            busy_n  = 1'b1;
            state_n = S_INIT_WAIT;
         end
         S_INIT_WAIT: begin
            if (SPI_DONE) begin
               busy_n = 1'b0;
               if (idx == INIT_LAST) begin
                  idx_n = '0;
`ifdef OLED_CLEAR_EN
                  page_n  = '0;
                  col_n   = '0;
                  state_n = S_CLR_ISSUE;
`else
                  ready_n = 1'b1;
                  state_n = S_IDLE;
`endif
               end else begin
                  idx_n   = idx + 5'd1;
                  state_n = S_INIT_ISSUE;
               end
            end
         end
`ifdef OLED_CLEAR_EN
         S_CLR_ISSUE: begin
            data_n  = clr_word(page, col);
            start_n = 1'b1;
            busy_n  = 1'b1;
            state_n = S_CLR_WAIT;
         end
         S_CLR_WAIT: begin
            if (SPI_DONE) begin
               busy_n = 1'b0;
               if (col == COL_LAST) begin
                  col_n = '0;
                  if (page == PAGE_LAST) begin
                     page_n  = '0;
                     ready_n = 1'b1;
                     state_n = S_IDLE;
                  end else begin
                     page_n  = page + 3'd1;
                     state_n = S_CLR_ISSUE;
                  end
               end else begin
                  col_n   = col + 8'd1;
                  state_n = S_CLR_ISSUE;
               end
            end
         end
`endif
         S_IDLE: begin
            ready_n = 1'b1;
            if (WR_VALID) begin
               data_n   = {1'b0, WR_DC, WR_BYTE};
               start_n  = 1'b1;
               accept_n = 1'b1;
               busy_n   = 1'b1;
               state_n  = S_USER_WAIT;
            end
         end
         S_USER_WAIT: begin
            if (SPI_DONE) begin
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_RST_LO;
      endcase
   end

   // State, counters and registered outputs; RST clears everything at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_RST_LO;
         cnt       <= '0;
         idx       <= '0;
         RES_N     <= 1'b0;
         SPI_DATA  <= 10'h000;
         SPI_START <= 1'b0;
         READY     <= 1'b0;
         WR_ACCEPT <= 1'b0;
         BUSY      <= 1'b0;
`ifdef OLED_CLEAR_EN
         page      <= '0;
         col       <= '0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         RES_N     <= res_n_n;
         SPI_DATA  <= data_n;
         SPI_START <= start_n;
         READY     <= ready_n;
         WR_ACCEPT <= accept_n;
         BUSY      <= busy_n;
`ifdef OLED_CLEAR_EN
         page      <= page_n;
         col       <= col_n;
`endif
      end
   end

endmodule

// File: tb/tb_oled_cmd_seq.sv
// tb_oled_cmd_seq: directed bench for oled_cmd_seq with a transmitter model
// answering DONE 20 cycles after each START and a scoreboard of expected words.
module tb_oled_cmd_seq;

   localparam int DONE_LAT = 20;
`ifdef OLED_CLEAR_EN
   localparam int N_SEQ = 25 + 8 * 131;
`else
   localparam int N_SEQ = 25;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       RES_N;
   logic [9:0] SPI_DATA;
   logic       SPI_START;
   logic       SPI_DONE;
   logic       READY;
   logic       WR_VALID;
   logic       WR_DC;
   logic [7:0] WR_BYTE;
   logic       WR_ACCEPT;
   logic       BUSY;

   oled_cmd_seq #(.RST_LOW_CYC(4), .PWR_DELAY(10)) dut (
      .CLK(CLK), .RST(RST), .RES_N(RES_N), .SPI_DATA(SPI_DATA),
      .SPI_START(SPI_START), .SPI_DONE(SPI_DONE), .READY(READY),
      .WR_VALID(WR_VALID), .WR_DC(WR_DC), .WR_BYTE(WR_BYTE),
      .WR_ACCEPT(WR_ACCEPT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         n_start  = 0;
   int         n_acc    = 0;
   int         n_pre_acc = 0;
   int         last_done = -100;
   int         last_acc  = -100;
   int         done_tmr  = 0;
   logic       outstanding = 1'b0;
   logic [9:0] sb [$];
   logic [9:0] exp_w;
   logic [7:0] rom [0:24];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_seq();
      for (int i = 0; i < 25; i++) sb.push_back({2'b00, rom[i]});
`ifdef OLED_CLEAR_EN
      for (int p = 0; p < 8; p++) begin
         sb.push_back({2'b00, 4'hB, 1'b0, 3'(p)});
         sb.push_back(10'h000);
         sb.push_back(10'h010);
         for (int c = 0; c < 128; c++) sb.push_back(10'h100);
      end
`endif
   endtask

   // One cycle: sample at the falling edge, score any START, run the DONE model.
   task automatic tick();
      @(negedge CLK);
      cyc++;
      if (SPI_START) begin
         n_start++;
         check("no_overlap", 32'(outstanding), 32'd0);
         check("busy_on_start", 32'(BUSY), 32'd1);
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_w = sb.pop_front();
            check("spi_data", 32'(SPI_DATA), 32'(exp_w));
         end
         outstanding = 1'b1;
         done_tmr    = DONE_LAT;
      end
      if (WR_ACCEPT) begin
         n_acc++;
         last_acc = cyc;
         if (!READY) n_pre_acc++;
      end
      SPI_DONE = 1'b0;
      if (done_tmr > 0) begin
         done_tmr--;
         if (done_tmr == 0) begin
            SPI_DONE    = 1'b1;
            outstanding = 1'b0;
            last_done   = cyc;
         end
      end
   endtask

   // Release reset, then check RES_N pulse width and first-START latency.
   task automatic power_up(input string tag);
      int k;
      int j;
      RST = 1'b0;
      push_seq();
      k = 0;
      while (RES_N === 1'b0 && k < 100) begin tick(); k++; end
      check({tag, "_res_n_low_cycles"}, 32'(k), 32'd4);
      j = 0;
      while (SPI_START !== 1'b1 && j < 50) begin tick(); j++; end
      check({tag, "_first_start_window"}, 32'(j >= 10 && j <= 11), 32'd1);
   endtask

   initial begin
      int g;
      int acc1;
      int st;
      rom = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
              8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
              8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
      RST      = 1'b1;
      SPI_DONE = 1'b0;
      // User request held high from the start: must not be taken before READY.
      WR_VALID = 1'b1;
      WR_DC    = 1'b1;
      WR_BYTE  = 8'hA5;
      repeat (3) tick();
      check("rst_res_n",  32'(RES_N), 32'd0);
      check("rst_data",   32'(SPI_DATA), 32'h000);
      check("rst_start",  32'(SPI_START), 32'd0);
      check("rst_ready",  32'(READY), 32'd0);
      check("rst_accept", 32'(WR_ACCEPT), 32'd0);
      check("rst_busy",   32'(BUSY), 32'd0);

      power_up("pwr1");

      // Reset while the transfer of init index 7 is outstanding.
      g = 0;
      while (n_start < 8 && g < 1000) begin tick(); g++; end
      check("reached_idx7", 32'(n_start), 32'd8);
      repeat (5) tick();
      check("mid_busy", 32'(BUSY), 32'd1);
      #2 RST = 1'b1;
      #1;
      check("mid_rst_res_n", 32'(RES_N), 32'd0);
      check("mid_rst_data",  32'(SPI_DATA), 32'h000);
      check("mid_rst_start", 32'(SPI_START), 32'd0);
      check("mid_rst_busy",  32'(BUSY), 32'd0);
      check("mid_rst_ready", 32'(READY), 32'd0);
      sb.delete();
      outstanding = 1'b0;
      done_tmr    = 0;
      SPI_DONE    = 1'b0;
      n_start     = 0;
      repeat (2) tick();

      power_up("pwr2");

      g = 0;
      while (READY !== 1'b1 && g < 40000) begin tick(); g++; end
      check("ready_seen", 32'(READY), 32'd1);
      check("ready_after_done", 32'(cyc - last_done), 32'd1);
      check("seq_transfers", 32'(n_start), 32'(N_SEQ));
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("no_accept_before_ready", 32'(n_pre_acc), 32'd0);

      // User port: held request is taken once, then again only after DONE.
      sb.push_back(10'h1A5);
      sb.push_back(10'h1A5);
      tick();
      check("acc1_pulse", 32'(WR_ACCEPT), 32'd1);
      check("acc1_start", 32'(SPI_START), 32'd1);
      acc1 = cyc;
      g = 0;
      while (n_acc < 2 && g < 200) begin tick(); g++; end
      check("acc2_seen", 32'(n_acc), 32'd2);
      check("acc2_after_done", 32'(last_acc > last_done && last_done > acc1), 32'd1);
      WR_VALID = 1'b0;
      repeat (25) tick();
      check("user_idle_busy", 32'(BUSY), 32'd0);
      check("user_sb_drained", 32'(sb.size()), 32'd0);
      check("user_acc_total", 32'(n_acc), 32'd2);

      // Stray DONE in IDLE must have no effect.
      st = n_start;
      SPI_DONE = 1'b1;
      repeat (3) tick();
      check("stray_done_no_start", 32'(n_start - st), 32'd0);
      check("stray_done_ready", 32'(READY), 32'd1);
      check("stray_done_busy", 32'(BUSY), 32'd0);

      // Single-cycle command byte request.
      sb.push_back(10'h081);
      WR_DC    = 1'b0;
      WR_BYTE  = 8'h81;
      WR_VALID = 1'b1;
      tick();
      WR_VALID = 1'b0;
      check("cmd_accept", 32'(WR_ACCEPT), 32'd1);
      repeat (25) tick();
      check("cmd_sb_drained", 32'(sb.size()), 32'd0);
      check("cmd_acc_total", 32'(n_acc), 32'd3);
      check("cmd_idle_busy", 32'(BUSY), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
